// File: rtl/sm_fixed_point_encoder.sv
// ---------------------------------------------------------------------------
// sm_fixed_point_encoder
//
// Purpose:
//   Converts signed two's-complement accumulator results into the 12-bit
//   S1.5.6 sign-magnitude format consumed by the tanh comparator and
//   segment-select logic.
//     bit 11     sign
//     bits 10:6  integer part
//     bits 5:0   fraction
//   The conversion is a two-stage valid/ready pipeline:
//     S1 registers the sign and the absolute value of the input word.
//     S2 rounds half away from zero to 6 fractional bits, saturates the
//        magnitude to 0x7FF and registers the sign-magnitude result.
//   Every saturated result accepted downstream bumps a saturating counter.
//
// Parameters:
//   IN_W     input word width (two's complement)
//   IN_FRAC  input fractional bits, must be >= 7 so the rounding bit exists
//   CNT_W    width of the saturation event counter
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_data    signed input word with IN_FRAC fractional bits
//   in_valid   in_data is valid
//   in_ready   block can accept in_data this cycle (combinational)
//   out_data   S1.5.6 sign-magnitude result
//   out_sat    out_data was saturated (qualified by out_valid)
//   out_valid  out_data/out_sat are valid
//   out_ready  downstream accepts out_data
//   sat_count  number of saturated results accepted downstream
//   sat_clr    synchronous clear of sat_count, wins over an increment
// ---------------------------------------------------------------------------
module sm_fixed_point_encoder #(
  parameter int IN_W    = 24,
  parameter int IN_FRAC = 12,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [11:0]      out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_clr
);

  // Right shift that drops the input fraction down to 6 bits.
  localparam int SH = IN_FRAC - 6;

  // Largest magnitude the 5.6 field can represent.
  localparam logic [IN_W:0] MAG_MAX = (IN_W+1)'(2047);

  // Stage 1 state
  logic            s1_valid_q, s1_valid_d;
  logic            s1_sign_q,  s1_sign_d;
  logic [IN_W-1:0] s1_mag_q,   s1_mag_d;

  // Stage 2 / output state
  logic             out_valid_q, out_valid_d;
  logic [11:0]      out_data_q,  out_data_d;
  logic             out_sat_q,   out_sat_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;

  // Handshake enables
  logic s2_en;
  logic s1_en;
  logic in_xfer;
  logic out_xfer;

  // Datapath intermediates
  logic            in_sign;
  logic [IN_W-1:0] in_mag;
  logic [IN_W:0]   q_full;
  logic            q_sat;
  logic [10:0]     q_mag;
  logic            q_sign;

  // Absolute value of the input. The unsigned IN_W-bit negation of the most
  // negative word yields 2^(IN_W-1), which is the correct magnitude, so no
  // wrap to a negative value can occur once the result is treated as unsigned.
  always_comb begin
    in_sign = in_data[IN_W-1];
    in_mag  = in_data;
    if (in_sign) begin
      in_mag = (~in_data) + IN_W'(1);
    end
  end

  // Round half away from zero on the magnitude, one bit wider than the
  // magnitude so the rounding carry out of the top bit is never lost.
  // A negative value that rounds to zero must not produce 0x800, so the
  // sign bit is qualified by a non-zero magnitude.
  always_comb begin
    q_full = ({1'b0, s1_mag_q} >> SH) + (IN_W+1)'(s1_mag_q[SH-1]);
    q_sat  = (q_full > MAG_MAX);
    q_mag  = q_sat ? 11'h7FF : q_full[10:0];
    q_sign = s1_sign_q && (q_mag != 11'd0);
  end

  // Pipeline control and next-state computation. S2 can advance when it is
  // empty or being drained; S1 can advance when it is empty or S2 advances.
  always_comb begin
    s2_en    = !out_valid_q || out_ready;
    s1_en    = !s1_valid_q || s2_en;
    in_xfer  = in_valid && s1_en;
    out_xfer = out_valid_q && out_ready;

    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_mag_d    = s1_mag_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sat_count_d = sat_count_q;

    if (s1_en) begin
      s1_valid_d = in_valid;
    end
    if (in_xfer) begin
      s1_sign_d = in_sign;
      s1_mag_d  = in_mag;
    end

    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = {q_sign, q_mag};
        out_sat_d  = q_sat;
      end
    end

    if (sat_clr) begin
      sat_count_d = '0;
    end else if (out_xfer && out_sat_q && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 12'h000;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign in_ready  = s1_en;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_sm_fixed_point_encoder.sv
// ---------------------------------------------------------------------------
// tb_sm_fixed_point_encoder
//
// Directed testbench for sm_fixed_point_encoder. Each input word is issued
// together with its hand-computed S1.5.6 result; a monitor pairs accepted
// inputs with accepted outputs in order and compares them.
// ---------------------------------------------------------------------------
module tb_sm_fixed_point_encoder;

  localparam int IN_W    = 24;
  localparam int IN_FRAC = 12;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [11:0]      out_data;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] sat_count;
  logic             sat_clr;

  sm_fixed_point_encoder #(
    .IN_W    (IN_W),
    .IN_FRAC (IN_FRAC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_count (sat_count),
    .sat_clr   (sat_clr)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [11:0] data;
    logic        sat;
    int          in_cycle;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] cur_exp_data;
  logic        cur_exp_sat;
  bit          check_latency = 1'b0;
  int          checks_total  = 0;
  int          checks_passed = 0;
  int          outputs_seen  = 0;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Monitor: sampled on the falling edge, half a cycle away from the edge on
  // which the transfers take effect.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      outputs_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_output", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(e.data));
        checkOutput("out_sat", 32'(out_sat), 32'(e.sat));
        if (check_latency) begin
          checkOutput("latency", 32'(cycle - e.in_cycle), 32'd2);
        end
      end
    end
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back('{cur_exp_data, cur_exp_sat, cycle});
    end
  end

  // Present one word and hold it until it is accepted. Called just after a
  // rising edge and returns just after the accepting edge, so consecutive
  // calls stream one word per cycle.
  task automatic applyStimulus(input logic [IN_W-1:0] d, input logic [11:0] ed,
                               input logic es);
    int waited = 0;
    in_data      = d;
    in_valid     = 1'b1;
    cur_exp_data = ed;
    cur_exp_sat  = es;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      if (waited > 50) begin
        checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait until every issued word has been seen at the output, then let the
  // final transfer edge pass.
  task automatic waitDrain();
    int waited = 0;
    @(negedge clk);
    while (exp_q.size() != 0) begin
      waited++;
      if (waited > 100) begin
        checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] held;
    bit          saw_in_ready_low;
    int          seen_before;
    int          waited;

    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'h000);
    checkOutput("reset_out_sat", 32'(out_sat), 32'd0);
    checkOutput("reset_sat_count", 32'(sat_count), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Nominal stream, back-to-back, fixed 2-cycle latency
    check_latency = 1'b1;
    applyStimulus(24'h001000, 12'h040, 1'b0);
    applyStimulus(24'hFFF000, 12'h840, 1'b0);
    applyStimulus(24'h000800, 12'h020, 1'b0);
    waitDrain();

    // Rounding and negative zero
    applyStimulus(24'h000020, 12'h001, 1'b0);
    applyStimulus(24'h00001F, 12'h000, 1'b0);
    applyStimulus(24'hFFFFE0, 12'h801, 1'b0);
    applyStimulus(24'hFFFFE1, 12'h000, 1'b0);
    waitDrain();
    check_latency = 1'b0;
    checkOutput("sat_count_no_sat", 32'(sat_count), 32'd0);

    // Saturation boundaries
    applyStimulus(24'h020000, 12'h7FF, 1'b1);
    applyStimulus(24'h800000, 12'hFFF, 1'b1);
    applyStimulus(24'h01FFE0, 12'h7FF, 1'b1);
    applyStimulus(24'h01FFDF, 12'h7FF, 1'b0);
    waitDrain();
    checkOutput("sat_count_3", 32'(sat_count), 32'd3);

    // Backpressure: 5 words with out_ready low for 4 cycles mid-stream
    seen_before      = outputs_seen;
    saw_in_ready_low = 1'b0;
    fork
      begin
        applyStimulus(24'h000040, 12'h001, 1'b0);
        applyStimulus(24'h000080, 12'h002, 1'b0);
        applyStimulus(24'hFFFF40, 12'h803, 1'b0);
        applyStimulus(24'h000100, 12'h004, 1'b0);
        applyStimulus(24'h000140, 12'h005, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = out_data;
        if (!in_ready) saw_in_ready_low = 1'b1;
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (3) begin
          @(negedge clk);
          checkOutput("bp_stall_stable", 32'(out_data), 32'(held));
          if (!in_ready) saw_in_ready_low = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp_in_ready_low", 32'(saw_in_ready_low), 32'd1);
    checkOutput("bp_output_count", 32'(outputs_seen - seen_before), 32'd5);

    // Counter saturation: 2^CNT_W + 3 saturated transfers
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      applyStimulus(24'h020000, 12'h7FF, 1'b1);
    end
    waitDrain();
    checkOutput("sat_count_hold", 32'(sat_count), 32'hFFFF);

    // sat_clr coinciding with a saturated transfer
    out_ready = 1'b0;
    applyStimulus(24'hFE0000, 12'hFFF, 1'b1);
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    checkOutput("clr_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    sat_clr   = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    checkOutput("sat_count_clr", 32'(sat_count), 32'd0);
    applyStimulus(24'h020000, 12'h7FF, 1'b1);
    waitDrain();
    checkOutput("sat_count_after_clr", 32'(sat_count), 32'd1);

    // Reset while both stages hold valid words
    out_ready = 1'b0;
    applyStimulus(24'h001000, 12'h040, 1'b0);
    applyStimulus(24'h002000, 12'h080, 1'b0);
    @(negedge clk);
    checkOutput("pre_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("pre_rst_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_out_data", 32'(out_data), 32'h000);
    checkOutput("async_rst_sat_count", 32'(sat_count), 32'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    out_ready   = 1'b1;
    seen_before = outputs_seen;
    applyStimulus(24'h000C00, 12'h030, 1'b0);
    waitDrain();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_output_count", 32'(outputs_seen - seen_before), 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
